// File: rtl/fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/HALT sequencer with a one-entry output register to decode.
// Optional FETCH_BOUND_EN macro halts with a fault when the PC leaves [0, MEM_DEPTH).
module fetch_unit #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_instr,
    output logic [7:0] instr,
    output logic [7:0] instr_pc,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_addr,
    input  logic       halt_req,
    output logic       halted,
    output logic       fault
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

`ifdef FETCH_BOUND_EN
    localparam logic BOUND_EN = 1'b1;
`else
    localparam logic BOUND_EN = 1'b0;
`endif

    logic [1:0] r_state;
    logic [7:0] r_pc;
    logic [7:0] r_instr;
    logic [7:0] r_instr_pc;
    logic       r_valid;
    logic       r_halted;
    logic       r_fault;

    logic [1:0] w_state_nxt;
    logic [7:0] w_pc_nxt;
    logic [7:0] w_instr_nxt;
    logic [7:0] w_instr_pc_nxt;
    logic       w_valid_nxt;
    logic       w_halted_nxt;
    logic       w_fault_nxt;

    logic       w_consume;
    logic       w_fetch_slot;
    logic       w_pc_oob;
    logic       w_bound_hit;

    assign w_consume    = r_valid && instr_ready;
    assign w_fetch_slot = !r_valid || instr_ready;
    assign w_pc_oob     = ({24'd0, r_pc} >= MEM_DEPTH);
    // Constant 0 when the bound check is compiled out, so fault never sets.
    assign w_bound_hit  = BOUND_EN && w_pc_oob;

    // Next-state and datapath decisions; redirect outranks everything outside BOOT.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_halted_nxt   = r_halted;
        w_fault_nxt    = r_fault;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt  = ST_RUN;
                w_halted_nxt = 1'b0;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    w_pc_nxt     = redirect_addr;
                    w_valid_nxt  = 1'b0;
                    w_fault_nxt  = 1'b0;
                    w_halted_nxt = 1'b0;
                    w_state_nxt  = ST_RUN;
                end else if (halt_req) begin
                    w_state_nxt  = ST_HALT;
                    w_halted_nxt = 1'b1;
                    if (w_consume) begin
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_valid_nxt = r_valid;
                    end
                end else if (w_fetch_slot) begin
                    if (w_bound_hit) begin
                        w_state_nxt  = ST_HALT;
                        w_halted_nxt = 1'b1;
                        w_fault_nxt  = 1'b1;
                        w_valid_nxt  = 1'b0;
                    end else begin
                        w_instr_nxt    = imem_instr;
                        w_instr_pc_nxt = r_pc;
                        w_valid_nxt    = 1'b1;
                        w_pc_nxt       = r_pc + 8'd1;
                    end
                end else begin
                    w_valid_nxt = r_valid;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    w_pc_nxt     = redirect_addr;
                    w_valid_nxt  = 1'b0;
                    w_fault_nxt  = 1'b0;
                    w_halted_nxt = 1'b0;
                    w_state_nxt  = ST_RUN;
                end else if (w_consume) begin
                    w_valid_nxt = 1'b0;
                end else begin
                    w_valid_nxt = r_valid;
                end
            end
            default: begin
                w_state_nxt  = ST_BOOT;
                w_pc_nxt     = RESET_PC;
                w_valid_nxt  = 1'b0;
                w_halted_nxt = 1'b0;
                w_fault_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_instr    <= 8'h00;
            r_instr_pc <= 8'h00;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_halted   <= w_halted_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign halted      = r_halted;
    assign fault       = r_fault;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001: Parameter RESET_PC, default 8'h00, the address of the first instruction fetched after reset.
REQ-002: Parameter MEM_DEPTH, default 32, the number of valid instruction-memory words; used only when FETCH_BOUND_EN is defined.
REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous and active-low.
REQ-005: imem_addr  output  8  combinational copy of the PC; drives the instruction memory Read_Address.
REQ-006: imem_instr  input  8  instruction returned combinationally by instruction memory for imem_addr.
REQ-007: instr  output  8  registered instruction presented to decode.
REQ-008: instr_pc  output  8  address from which instr was fetched.
REQ-009: instr_valid  output  1  instr/instr_pc hold a live instruction.
REQ-010: instr_ready  input  1  decode accepts instr this cycle.
REQ-011: redirect_valid  input  1  branch/jump taken; load the PC from redirect_addr.
REQ-012: redirect_addr  input  8  branch/jump target.
REQ-013: halt_req  input  1  stop fetching new instructions.
REQ-014: halted  output  1  fetch is in HALT.
REQ-015: fault  output  1  fetch stopped on an out-of-range PC (FETCH_BOUND_EN only; otherwise tied 0).

Function
REQ-016: The block SHALL implement three states: BOOT, RUN and HALT.
REQ-017: BOOT SHALL last exactly one cycle after reset release.
  - No fetch occurs in BOOT, and instr_valid SHALL stay 0.
  - The next state SHALL be RUN.
REQ-018: The unit SHALL fire a fetch in RUN when (!instr_valid || instr_ready) and no redirect is present.
  - On a fetch: instr <= imem_instr, instr_pc <= pc, instr_valid <= 1, pc <= pc+1.
REQ-019: Latency: an instruction at address A SHALL appear on instr one cycle after imem_addr==A in RUN.
  - The sustained rate SHALL be one instruction per cycle while instr_ready=1.
REQ-020: Stall: when instr_valid && !instr_ready, instr, instr_pc, instr_valid and pc SHALL hold unchanged.
REQ-021: Drain: when instr_valid && instr_ready and no fetch fires, instr_valid SHALL go to 0 the next cycle.
REQ-022: Redirect SHALL take priority over fetch, stall and halt_req in every state except BOOT.
  - It sets pc <= redirect_addr and instr_valid <= 0, flushing the held instruction.
  - It sets fault <= 0 and state <= RUN.
  - The target is fetched on the following cycle.
REQ-023: A redirect in BOOT SHALL be ignored.
REQ-024: halt_req in RUN without redirect SHALL move the state to HALT with no fetch that cycle.
  - pc is frozen; the held instruction remains valid until consumed.
REQ-025: HALT SHALL perform no fetches and SHALL drive halted=1.
  - Only a redirect or a reset exits HALT.
REQ-026: The PC SHALL be 8 bits and SHALL wrap from 8'hFF to 8'h00 with no side effect (FETCH_BOUND_EN undefined).
REQ-027: A stall and a redirect in the same cycle SHALL resolve as a redirect; the stalled instruction is discarded.

Reset
REQ-028: rst_n low SHALL, asynchronously and in any state including mid-stall, force:
  - pc=RESET_PC, instr=8'h00, instr_pc=8'h00, instr_valid=0;
  - state=BOOT, halted=0, fault=0.
REQ-029: The release of rst_n SHALL take effect on the next rising edge of clk.

Configuration
REQ-030: Macro FETCH_BOUND_EN defined: a fetch attempt with pc >= MEM_DEPTH SHALL NOT load instr.
  - It SHALL enter HALT with fault=1 and halted=1.
  - A redirect clears fault and resumes RUN.
REQ-031: Macro FETCH_BOUND_EN undefined: no range check SHALL be performed, fault SHALL be constant 0, and the PC wraps per REQ-026.

Verification
REQ-032: Reset, then instr_ready=1 with memory words 0..3 = 41,C1,C1,59 (hex) -> valid low for cycles 0-1, then instr=41,C1,C1,59 with instr_pc=0,1,2,3 on consecutive cycles.
REQ-033: instr_ready=0 for 3 cycles while instr_pc=2 -> instr, instr_pc and imem_addr=3 are held; on release, instr_pc=3 follows.
REQ-034: redirect_valid=1, redirect_addr=8'h09 while stalled at instr_pc=5 -> next cycle instr_valid=0, imem_addr=9; following cycle instr_pc=9.
REQ-035: halt_req=1 at pc=6 -> halted=1 and imem_addr stays 6 for 10 cycles; a redirect to 0 resumes fetch at 0.
REQ-036: Bound/wrap check, in two parts:
  - FETCH_BOUND_EN defined, MEM_DEPTH=32, redirect to 8'h1F -> instr_pc=1F is delivered, then fault=1, halted=1, no further valid instruction.
  - FETCH_BOUND_EN undefined, redirect to 8'hFF -> instr_pc FF then 00.
REQ-037: rst_n asserted mid-stall with instr_valid=1 -> instr_valid=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.
